uart_rx_fifo_bridge: RTL

Receive front-end between the `rx` pin and the UART register file read by the core. It synchronizes and oversamples the serial line, deserializes 8N1 frames (optionally with parity), and queues bytes in a small first-word-fall-through FIFO. The core drains the FIFO one byte per `rd_en` pulse decoded from the UART register select. It also produces sticky error flags and the activity indicator `heard_bit_out`.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_rx_sync_fifo.sv | 52 +++++
 rtl/uart_rx_fifo_bridge.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive bridge.
// UART_RX_PARITY_EN adds the PARITY state to the receive FSM.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_e;

  localparam int         OVERSAMPLE = 16;
  localparam logic [3:0] TICK_LAST  = 4'd15;
  localparam logic [3:0] VOTE_T0    = 4'd7;
  localparam logic [3:0] VOTE_T1    = 4'd8;
  localparam logic [3:0] VOTE_T2    = 4'd9;

  // Oversample divider, floored, never below 1.
  function automatic int uart_div(input int clk_freq, input int baud);
    int d;
    d = clk_freq / (baud * OVERSAMPLE);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO lands only when a pop
// happens in the same cycle.
module uart_rx_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          w_wr, w_rd;

  assign w_wr = push && (!full || pop);
  assign w_rd = pop && !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= din;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_mem[r_rptr];
  assign empty = (r_count == '0);
  assign full  = (r_count == (AW+1)'(DEPTH));
  assign count = r_count;

endmodule

// File: rtl/uart_rx_fifo_bridge.sv
// UART receive front-end: rx synchronizer, 16x oversampler, frame FSM, sticky
// error flags and byte FIFO. Optional parity checking under UART_RX_PARITY_EN.
module uart_rx_fifo_bridge
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd_en,
  input  logic       clr_err,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_full,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err,
  output logic       heard_bit_out
);
  localparam int             DIV      = uart_div(CLK_FREQ, BAUD);
  localparam int             DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0]  DIV_LAST = DW'(DIV - 1);
  localparam int             AW       = $clog2(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_rx_fifo_bridge: bad FIFO_DEPTH or PARITY_ODD");
  end

  logic [1:0]    r_sync;
  logic          r_rx_prev;
  rx_state_e     r_state;
  logic [DW-1:0] r_div;
  logic [3:0]    r_tcnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_v0, r_v1, r_push, r_par_bad, r_frame_err, r_overrun;
  logic          w_rx_s, w_tick, w_vote, w_decide, w_bit_end, w_par_mis;
  logic          w_empty, w_full;
  logic [AW:0]   w_count;

  assign w_rx_s    = r_sync[1];
  assign w_tick    = (r_state != ST_IDLE) && (r_div == DIV_LAST);
  assign w_vote    = (r_v0 & r_v1) | (r_v0 & w_rx_s) | (r_v1 & w_rx_s);
  assign w_decide  = w_tick && (r_tcnt == VOTE_T2);
  assign w_bit_end = w_tick && (r_tcnt == TICK_LAST);

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = PARITY_ODD[0];
  assign w_par_mis = w_decide && (r_state == ST_PARITY) && (w_vote != (^r_shift ^ PAR_ODD));
`else
  assign w_par_mis = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync    <= 2'b11;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync    <= {r_sync[0], rx};
      r_rx_prev <= w_rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_div     <= '0;
      r_tcnt    <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_v0      <= 1'b1;
      r_v1      <= 1'b1;
      r_push    <= 1'b0;
      r_par_bad <= 1'b0;
    end else begin
      r_push <= 1'b0;
      // Divider is held at 0 while idle so every frame starts on a fresh bit.
      if (r_state == ST_IDLE || w_tick) r_div <= '0;
      else                              r_div <= r_div + 1'b1;
      if (w_tick) r_tcnt <= r_tcnt + 1'b1;
      if (w_tick && r_tcnt == VOTE_T0) r_v0 <= w_rx_s;
      if (w_tick && r_tcnt == VOTE_T1) r_v1 <= w_rx_s;
      if (w_par_mis) r_par_bad <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          r_tcnt <= '0;
          if (r_rx_prev && !w_rx_s) begin
            r_state   <= ST_START;
            r_par_bad <= 1'b0;
          end
        end
        ST_START: begin
          if (w_decide && w_vote) r_state <= ST_IDLE;
          else if (w_bit_end) begin
            r_state <= ST_DATA;
            r_bit   <= '0;
          end
        end
        ST_DATA: begin
          if (w_decide) r_shift <= {w_vote, r_shift[7:1]};
          if (w_bit_end) begin
            r_bit <= r_bit + 1'b1;
            if (r_bit == 3'd7)
`ifdef UART_RX_PARITY_EN
              r_state <= ST_PARITY;
`else
              r_state <= ST_STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: if (w_bit_end) r_state <= ST_STOP;
`endif
        ST_STOP: begin
          // Leave at mid-stop-bit so the next start edge is never missed.
          if (w_decide) begin
            if (w_vote) begin
              r_push  <= !r_par_bad;
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_WAIT_IDLE;
            end
          end
        end
        ST_WAIT_IDLE: if (w_rx_s) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_decide && r_state == ST_STOP && !w_vote) r_frame_err <= 1'b1;
      else if (clr_err)                              r_frame_err <= 1'b0;
      // count MSB is set only when the FIFO holds DEPTH entries
      if (r_push && w_count[AW] && !rd_en) r_overrun <= 1'b1;
      else if (clr_err)                    r_overrun <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_err;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           r_par_err <= 1'b0;
    else if (w_par_mis) r_par_err <= 1'b1;
    else if (clr_err)   r_par_err <= 1'b0;
  end
  assign parity_err = r_par_err;
`else
  assign parity_err = 1'b0;
`endif

  uart_rx_sync_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (r_push),
    .pop   (rd_en),
    .din   (r_shift),
    .dout  (rx_data),
    .empty (w_empty),
    .full  (w_full),
    .count (w_count)
  );

  assign rx_valid      = !w_empty;
  assign rx_full       = w_full;
  assign frame_err     = r_frame_err;
  assign overrun       = r_overrun;
  assign heard_bit_out = (r_state != ST_IDLE);

endmodule
